// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and
// decode helpers for the iterative mul/div unit.
package muldiv_pkg;

  localparam int unsigned N_ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_arith(
    input logic [2:0] op
  );
    return ~op[2];
  endfunction

  function automatic logic op_is_div(
    input logic [2:0] op
  );
    return op[1];
  endfunction

  function automatic logic op_is_signed(
    input logic [2:0] op
  );
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the
// EX stage and the mul/div unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, flush,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output hi, lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier and
// restoring divider sharing one register pair.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = N_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;

  // opnd: multiplicand or divisor magnitude
  // acc_hi: partial product / remainder
  // acc_lo: multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             div_q, div_d;
  logic             nres_q, nres_d;
  logic             nrem_q, nrem_d;
  logic             dz_q, dz_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   sub;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_f;
  logic [WIDTH-1:0] quo_f;
  logic [WIDTH-1:0] rem_f;

  // operand magnitudes and one iteration step
  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    a_mag   = a_neg ? (~a + 1'b1) : a;
    b_mag   = b_neg ? (~b + 1'b1) : b;
    add_sum = {1'b0, acc_hi_q}
            + (acc_lo_q[0] ? {1'b0, opnd_q}
                           : '0);
    shl     = {acc_hi_q, acc_lo_q[WIDTH-1]};
    sub     = shl - {1'b0, opnd_q};

    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    div_d    = div_q;
    nres_d   = nres_q;
    nrem_d   = nrem_q;
    dz_d     = dz_q;

    if (load) begin
      div_d    = is_div;
      opnd_d   = is_div ? b_mag : a_mag;
      acc_lo_d = is_div ? a_mag : b_mag;
      acc_hi_d = '0;
      nres_d   = a_neg ^ b_neg;
      nrem_d   = a_neg;
      dz_d     = is_div & (b == '0);
    end else if (step) begin
      if (div_q) begin
        if (!sub[WIDTH]) begin
          acc_hi_d = sub[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = shl[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = add_sum[WIDTH:1];
        acc_lo_d = {add_sum[0],
                    acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  // sign fix-up of the finished result
  always_comb begin
    prod   = {acc_hi_q, acc_lo_q};
    prod_f = nres_q ? (~prod + 1'b1) : prod;
    quo_f  = nres_q ? (~acc_lo_q + 1'b1)
                    : acc_lo_q;
    rem_f  = nrem_q ? (~acc_hi_q + 1'b1)
                    : acc_hi_q;
    res_hi = '0;
    res_lo = '0;
    if (fix) begin
      if (div_q) begin
        res_hi = rem_f;
        res_lo = dz_q ? '1 : quo_f;
      end else begin
        res_hi = prod_f[W2-1:WIDTH];
        res_lo = prod_f[WIDTH-1:0];
      end
    end
  end

  assign div_zero = dz_q;

  // datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      div_q    <= 1'b0;
      nres_q   <= 1'b0;
      nrem_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      div_q    <= div_d;
      nres_q   <= nres_d;
      nrem_q   <= nrem_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO owner, sequencing FSM and
// stall handshake around muldiv_datapath.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = N_ITER
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             load;
  logic             step;
  logic             fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             dz;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .is_div   (op_is_div(bus.op)),
    .is_signed(op_is_signed(bus.op)),
    .a        (bus.src_a),
    .b        (bus.src_b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (dz)
  );

  // next state, strobes and HI/LO updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          unique case (1'b1)
            op_is_arith(bus.op): begin
              state_d = S_RUN;
              busy_d  = 1'b1;
              cnt_d   = '0;
              load    = 1'b1;
            end
            (bus.op == OP_MTHI):
              hi_d = bus.src_a;
            (bus.op == OP_MTLO):
              lo_d = bus.src_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          fix    = 1'b1;
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
          dbz_d  = dz;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // control and architectural registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, corner-case
// sequences and randomized model comparison.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h",
                  name, act, exp);
  endtask

  // caller sits at a negedge; returns at the
  // negedge where done is seen (lat = 34)
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat,
                        output int bcnt,
                        output logic dzs);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clock);
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    dzs  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k;
        dzs = bus.div_by_zero;
        break;
      end
      @(negedge clock);
    end
  endtask

  // reference computed with 64-bit arithmetic
  task automatic model(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] h,
                       output logic [31:0] l,
                       output logic dz);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    dz = 1'b0;
    case (op)
      OP_MULT: begin
        p = sa * sb;
        {h, l} = p;
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {h, l} = p;
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          h = a;
          l = '1;
        end else if (op == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          l = sq[31:0];
          h = sr[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  initial begin
    int lat, bcnt, seen;
    logic dzs;
    logic [31:0] eh, el;
    logic edz;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"multu_max", OP_MULTU,
      32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{"mult_m3x7", OP_MULT,
      32'hFFFFFFFD, 32'd7,
      32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{"mult_min2", OP_MULT,
      32'h80000000, 32'h80000000,
      32'h40000000, 32'h00000000, 1'b0};
    vecs[3] = '{"div_m7d2", OP_DIV,
      32'hFFFFFFF9, 32'd2,
      32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{"divu_100d7", OP_DIVU,
      32'd100, 32'd7,
      32'd2, 32'd14, 1'b0};
    vecs[5] = '{"div_ovf", OP_DIV,
      32'h80000000, 32'hFFFFFFFF,
      32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{"divu_5d0", OP_DIVU,
      32'd5, 32'd0,
      32'd5, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{"div_m5d0", OP_DIV,
      32'hFFFFFFFB, 32'd0,
      32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{"div_7dm2", OP_DIV,
      32'd7, 32'hFFFFFFFE,
      32'd1, 32'hFFFFFFFD, 1'b0};
    vecs[9] = '{"multu_6x7", OP_MULTU,
      32'd6, 32'd7,
      32'd0, 32'd42, 1'b0};

    bus.start = 1'b0;
    bus.op    = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_state",
        72'({bus.hi, bus.lo, bus.busy,
             bus.done, bus.div_by_zero}),
        72'd0);

    // table runs back to back: each start is
    // issued on the cycle the previous done is up
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             lat, bcnt, dzs);
      chk({vecs[i].name, "_res"},
          72'({bus.hi, bus.lo, dzs}),
          72'({vecs[i].hi, vecs[i].lo,
               vecs[i].dz}));
      chk({vecs[i].name, "_lat"},
          72'(lat), 72'd34);
      chk({vecs[i].name, "_busy"},
          72'(bcnt), 72'd33);
    end
    @(negedge clock);
    chk("done_one_cycle",
        72'({bus.done, bus.busy}), 72'd0);

    // op 11x is ignored
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.src_a = 32'hDEADBEEF;
    @(negedge clock);
    bus.start = 1'b0;
    chk("op11x_ignored",
        72'({bus.hi, bus.lo, bus.busy}),
        72'({32'd0, 32'd42, 1'b0}));

    // flush beats start in IDLE
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.flush = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clock);
    chk("flush_start_idle",
        72'({bus.busy, bus.done}), 72'd0);

    // MTHI / MTLO, each visible next cycle
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.src_a = 32'h1234;
    @(negedge clock);
    chk("mthi", 72'({bus.hi, bus.busy,
        bus.done}), 72'({32'h1234, 2'b00}));
    bus.op    = OP_MTLO;
    bus.src_a = 32'h5678;
    @(negedge clock);
    bus.start = 1'b0;
    chk("mtlo", 72'({bus.lo, bus.busy,
        bus.done}), 72'({32'h5678, 2'b00}));

    // flush at RUN cycle 10
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.src_a = 32'h11111111;
    bus.src_b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++)
      @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_busy_low",
        72'({bus.busy, bus.done}), 72'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) seen++;
      @(negedge clock);
    end
    chk("flush_no_done", 72'(seen), 72'd0);
    chk("flush_keep_hilo",
        72'({bus.hi, bus.lo}),
        72'({32'h1234, 32'h5678}));

    // start pulses while busy are ignored
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    @(negedge clock);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      bus.start = (k % 4 == 0);
      bus.op    = (k % 8 == 0) ? OP_MTHI
                               : OP_DIVU;
      bus.src_a = 32'hDEAD0000 + k;
      bus.src_b = '0;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    chk("busy_start_lat", 72'(lat), 72'd34);
    chk("busy_start_res",
        72'({bus.hi, bus.lo, bus.div_by_zero}),
        72'({32'd0, 32'd42, 1'b0}));

    // reset at RUN cycle 20
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.src_a = 32'hAAAA5555;
    @(negedge clock);
    bus.op    = OP_MULTU;
    bus.src_a = 32'hFFFFFFFF;
    bus.src_b = 32'hFFFFFFFF;
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 1; k < 20; k++)
      @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset_mid_op",
        72'({bus.hi, bus.lo, bus.busy,
             bus.done, bus.div_by_zero}),
        72'd0);
    run_op(OP_MULTU, 32'd6, 32'd7,
           lat, bcnt, dzs);
    chk("after_reset_res",
        72'({bus.hi, bus.lo, dzs}),
        72'({32'd0, 32'd42, 1'b0}));
    chk("after_reset_lat", 72'(lat), 72'd34);

    // randomized operations against the model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h80000000;
        3: rb = '1;
        default: ;
      endcase
      model(rop, ra, rb, eh, el, edz);
      run_op(rop, ra, rb, lat, bcnt, dzs);
      chk($sformatf("rand%0d_op%0d", i, rop),
          72'({bus.hi, bus.lo, dzs}),
          72'({eh, el, edz}));
      chk($sformatf("rand%0d_lat", i),
          72'(lat), 72'd34);
    end

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage, consuming the two operand words latched by the ID/EX pipeline register. It owns the architectural HI/LO registers. It raises `busy` so hazard logic deasserts the ID/EX write enable until the result is ready. One operation is in flight at a time; MTHI/MTLO are single-cycle writes.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits; iteration count equals `WIDTH`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `start`  in  1  request, sampled only in IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `src_a`  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
- `src_b`  in  WIDTH  rt operand (multiplier/divisor).
- `flush`  in  1  abort in-flight operation (branch/exception squash).
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in flight; stall request to hazard unit.
- `done`  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- `div_by_zero`  out  1  pulses with `done` when a DIV/DIVU had `src_b == 0`.

## Operation
- Reset: `hi`, `lo`, `busy`, `done`, `div_by_zero` = 0; state IDLE; iteration counter = 0.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on `start` with op 000–011.
  - RUN -> FIX after `WIDTH` iterations.
  - FIX -> IDLE unconditionally.
  - RUN/FIX -> IDLE on `flush`.
- Start edge: latch operand magnitudes, result sign, remainder sign, op class, and the zero-divisor flag.
  - Signed ops (MULT, DIV) use absolute values.
  - Unsigned ops use the operands unchanged.
- MULT/MULTU: radix-2 shift-add into a 2×WIDTH accumulator, one multiplier bit per RUN cycle. FIX negates the full 2×WIDTH product if signs differ. HI = upper half, LO = lower half.
- DIV/DIVU: restoring division, one quotient bit per RUN cycle.
  - FIX negates the quotient if signs differ and negates the remainder if the dividend was negative.
  - Quotient truncates toward zero; LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) yields LO = 0x80000000, HI = 0, with no special case.
- Divide by zero: runs full latency, then HI = original `src_a`, LO = all ones, `div_by_zero` = 1 with `done`.
- MTHI/MTLO: on a `start` edge in IDLE, write `src_a` to HI/LO. No busy, no `done`.
- Op 11x with `start`: ignored.
- `start` while `busy`: ignored. Upstream holds the instruction stalled.
- `flush`:
  - In RUN/FIX: next edge returns to IDLE; HI/LO keep their pre-operation values; no `done`.
  - `flush` with `start` in IDLE: `flush` wins, nothing starts.
- `reset` has priority over everything, including mid-operation.

## Timing
- Start edge E0. `busy` = 1 from after E0 through E33.
- RUN occupies edges E1..E32; FIX is entered after E32.
- Edge E33 writes HI/LO, sets `done` (and `div_by_zero` if applicable) for exactly one cycle, and clears `busy`.
- Total latency: 33 cycles from the start edge to visible HI/LO.
- A new `start` is accepted on the same edge that `done` is high (back-to-back throughput = 34 cycles).
- MTHI/MTLO value is visible one cycle after its edge.
- `busy` is fully registered; no combinational path from inputs to outputs.

## Structure
- Package `muldiv_pkg` holds:
  - op encoding localparams (`OP_MULT` … `OP_MTLO`);
  - FSM state enum (IDLE/RUN/FIX);
  - the iteration-count constant.
- One sub-module, `muldiv_datapath`: accumulator/remainder/quotient shift registers, the add/subtract step, and sign fix-up. It is controlled by `step`/`fix` strobes.
- Top-level `muldiv_unit` holds the FSM, counter, HI/LO registers and handshake.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001; `busy` high 33 cycles; `done` exactly 1 cycle.
- MULT −3 × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 5 / 0 -> HI = 5, LO = 0xFFFFFFFF, `div_by_zero` = 1 with `done`. Back-to-back start on the `done` cycle is accepted.
- HI/LO preloaded via MTHI 0x1234, MTLO 0x5678 (each visible next cycle); then MULT, `flush` at RUN cycle 10 -> `busy` low next cycle, HI/LO still 0x1234/0x5678, no `done`. `start` pulses during `busy` leave the result unchanged.
- `reset` asserted at RUN cycle 20 -> next edge all outputs 0, IDLE. A fresh MULTU 6 × 7 then yields LO = 42.
